// File: rtl/primos_pares_core.sv
// Registered 4-bit prime / even classifier with optional saturating event counters.
// Latency: 1 cycle from the sampling CLK edge to PRIMOS/PARES/VALID (and counters).
// Backpressure: none; a sample is taken on every edge with EN = 1, EN = 0 holds the flags.
//
// Optional feature macro: PRIMOS_PARES_CNT_EN
//   defined   -> CNT_PRIMOS / CNT_PARES count prime / even samples since reset, saturating.
//   undefined -> no counter registers; CNT_PRIMOS / CNT_PARES are tied to zero.
module primos_pares_core #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             C,
  input  logic             B,
  input  logic             A,
  output logic             PRIMOS,
  output logic             PARES,
  output logic             VALID,
  output logic [CNT_W-1:0] CNT_PRIMOS,
  output logic [CNT_W-1:0] CNT_PARES
);

  // Nibble under test, D is the MSB.
  logic [3:0] nibble;
  logic       is_prime;
  logic       is_even;

  assign nibble = {D, C, B, A};

  // Classic two-output truth table: prime set {2,3,5,7,11,13}, even means LSB clear.
  always_comb begin
    is_prime = 1'b0;
    is_even  = ~A;
    case (nibble)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime = 1'b1;
      default:                              is_prime = 1'b0;
    endcase
  end

  // Flag registers: reset wins over EN, EN = 0 holds the flags but drops VALID.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PRIMOS <= 1'b0;
      PARES  <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      VALID <= EN;
      if (EN) begin
        PRIMOS <= is_prime;
        PARES  <= is_even;
      end
    end
  end

`ifdef PRIMOS_PARES_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_primos_q;
  logic [CNT_W-1:0] cnt_pares_q;

  // Event counters: both may step on the same sample (N = 2); they stick at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_primos_q <= '0;
      cnt_pares_q  <= '0;
    end else if (EN) begin
      if (is_prime && (cnt_primos_q != CNT_MAX)) begin
        cnt_primos_q <= cnt_primos_q + CNT_ONE;
      end
      if (is_even && (cnt_pares_q != CNT_MAX)) begin
        cnt_pares_q <= cnt_pares_q + CNT_ONE;
      end
    end
  end

  assign CNT_PRIMOS = cnt_primos_q;
  assign CNT_PARES  = cnt_pares_q;
`else
  // Counter-less build: outputs exist for a uniform port list but carry no state.
  assign CNT_PRIMOS = '0;
  assign CNT_PARES  = '0;
`endif

endmodule

// File: tb/tb_primos_pares_core.sv
// Directed, table-driven bench for primos_pares_core.
// Two instances share stimulus: CNT_W = 8 (sweep totals) and CNT_W = 2 (saturation).
// Counter expectations follow the build: zero unless PRIMOS_PARES_CNT_EN is defined.
module tb_primos_pares_core;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       D, C, B, A;
  logic       primos8, pares8, valid8;
  logic [7:0] cnt_primos8, cnt_pares8;
  logic       primos2, pares2, valid2;
  logic [1:0] cnt_primos2, cnt_pares2;

  primos_pares_core #(.CNT_W(8)) dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .C(C), .B(B), .A(A),
    .PRIMOS(primos8), .PARES(pares8), .VALID(valid8),
    .CNT_PRIMOS(cnt_primos8), .CNT_PARES(cnt_pares8)
  );

  primos_pares_core #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .C(C), .B(B), .A(A),
    .PRIMOS(primos2), .PARES(pares2), .VALID(valid2),
    .CNT_PRIMOS(cnt_primos2), .CNT_PARES(cnt_pares2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] n;
    logic       e_pr;
    logic       e_pa;
    logic       e_v;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_fail;
  int   m8_pr, m8_pa, m2_pr, m2_pa;

  task automatic add(input logic rst, input logic en, input int n,
                     input logic pr, input logic pa, input logic v, input string tag);
    vec_t t;
    t.rst = rst; t.en = en; t.n = n[3:0];
    t.e_pr = pr; t.e_pa = pa; t.e_v = v; t.tag = tag;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  initial begin
    n_cmp = 0; n_fail = 0;
    m8_pr = 0; m8_pa = 0; m2_pr = 0; m2_pa = 0;
    RST = 1'b1; EN = 1'b0; {D, C, B, A} = 4'd0;

    //   rst  en   n  prim pare valid tag
    add(1'b1, 1'b1, 2,  1'b0, 1'b0, 1'b0, "reset0");
    add(1'b1, 1'b1, 2,  1'b0, 1'b0, 1'b0, "reset1");
    add(1'b0, 1'b1, 0,  1'b0, 1'b1, 1'b1, "sweep0");
    add(1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, "sweep1");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sweep2");
    add(1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b1, "sweep3");
    add(1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b1, "sweep4");
    add(1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b1, "sweep5");
    add(1'b0, 1'b1, 6,  1'b0, 1'b1, 1'b1, "sweep6");
    add(1'b0, 1'b1, 7,  1'b1, 1'b0, 1'b1, "sweep7");
    add(1'b0, 1'b1, 8,  1'b0, 1'b1, 1'b1, "sweep8");
    add(1'b0, 1'b1, 9,  1'b0, 1'b0, 1'b1, "sweep9");
    add(1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1, "sweep10");
    add(1'b0, 1'b1, 11, 1'b1, 1'b0, 1'b1, "sweep11");
    add(1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b1, "sweep12");
    add(1'b0, 1'b1, 13, 1'b1, 1'b0, 1'b1, "sweep13");
    add(1'b0, 1'b1, 14, 1'b0, 1'b1, 1'b1, "sweep14");
    add(1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1, "sweep15");
    add(1'b0, 1'b1, 7,  1'b1, 1'b0, 1'b1, "hold_load7");
    add(1'b0, 1'b0, 4,  1'b1, 1'b0, 1'b0, "hold_en0_n4");
    add(1'b0, 1'b0, 9,  1'b1, 1'b0, 1'b0, "hold_en0_n9");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "dual_n2");
    add(1'b1, 1'b1, 2,  1'b0, 1'b0, 1'b0, "sat_reset");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sat1");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sat2");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sat3");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sat4");
    add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, "sat5");
    add(1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b1, "mid_n3");
    add(1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b1, "mid_n4");
    add(1'b1, 1'b1, 5,  1'b0, 1'b0, 1'b0, "mid_rst_n5");
    add(1'b0, 1'b1, 6,  1'b0, 1'b1, 1'b1, "mid_n6");
    add(1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0, "rst_en0");
    add(1'b0, 1'b0, 13, 1'b0, 1'b0, 1'b0, "idle_after_rst");
    add(1'b0, 1'b1, 13, 1'b1, 1'b0, 1'b1, "first_after_rst");

    @(negedge CLK);
    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst;
      EN  = vecs[i].en;
      {D, C, B, A} = vecs[i].n;
      @(posedge CLK);
      if (vecs[i].rst) begin
        m8_pr = 0; m8_pa = 0; m2_pr = 0; m2_pa = 0;
      end else if (vecs[i].en) begin
        if (vecs[i].e_pr) begin m8_pr = sat_inc(m8_pr, 255); m2_pr = sat_inc(m2_pr, 3); end
        if (vecs[i].e_pa) begin m8_pa = sat_inc(m8_pa, 255); m2_pa = sat_inc(m2_pa, 3); end
      end
      @(negedge CLK);
      check({vecs[i].tag, ".primos"}, int'(primos8), int'(vecs[i].e_pr));
      check({vecs[i].tag, ".pares"},  int'(pares8),  int'(vecs[i].e_pa));
      check({vecs[i].tag, ".valid"},  int'(valid8),  int'(vecs[i].e_v));
      check({vecs[i].tag, ".primos_w2"}, int'(primos2), int'(vecs[i].e_pr));
      check({vecs[i].tag, ".pares_w2"},  int'(pares2),  int'(vecs[i].e_pa));
      check({vecs[i].tag, ".valid_w2"},  int'(valid2),  int'(vecs[i].e_v));
`ifdef PRIMOS_PARES_CNT_EN
      check({vecs[i].tag, ".cnt_primos"},    int'(cnt_primos8), m8_pr);
      check({vecs[i].tag, ".cnt_pares"},     int'(cnt_pares8),  m8_pa);
      check({vecs[i].tag, ".cnt_primos_w2"}, int'(cnt_primos2), m2_pr);
      check({vecs[i].tag, ".cnt_pares_w2"},  int'(cnt_pares2),  m2_pa);
      if (vecs[i].tag == "sweep15") begin
        check("sweep_total.cnt_primos", int'(cnt_primos8), 6);
        check("sweep_total.cnt_pares",  int'(cnt_pares8),  8);
      end
      if (vecs[i].tag == "sat5") begin
        check("sat_final.cnt_primos_w2", int'(cnt_primos2), 3);
        check("sat_final.cnt_pares_w2",  int'(cnt_pares2),  3);
      end
      if (vecs[i].tag == "mid_n6") begin
        check("mid_n6.cnt_pares_hand", int'(cnt_pares8), 1);
      end
`else
      check({vecs[i].tag, ".cnt_primos_tied"},    int'(cnt_primos8), 0);
      check({vecs[i].tag, ".cnt_pares_tied"},     int'(cnt_pares8),  0);
      check({vecs[i].tag, ".cnt_primos_w2_tied"}, int'(cnt_primos2), 0);
      check({vecs[i].tag, ".cnt_pares_w2_tied"},  int'(cnt_pares2),  0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
